// File: rtl/loadarch_restore_sequencer.sv
// Architectural-state restore engine: checks the LOADARCH header, replays 86 state words
// into the tile restore port while core reset is held, then releases reset after a settle delay.
module loadarch_restore_sequencer #(
   parameter logic [63:0] MAGIC          = 64'h4C4F_4144_4152_4348,
   parameter int unsigned RELEASE_DELAY  = 16,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_bits,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [1:0]  wr_space,
   output logic [4:0]  wr_idx,
   output logic [63:0] wr_data,
   output logic        core_reset_hold,
   output logic        done,
   output logic        error,
   output logic [1:0]  error_code,
   output logic [6:0]  words_loaded,
   output logic [2:0]  fsm_state
);
   // Both ports transfer a word only on a rising edge where valid && ready are high; valid never
   // waits on ready, and wr_space/wr_idx/wr_data stay frozen while wr_valid && !wr_ready.

   localparam logic [6:0] NUM_WORDS   = 7'd86;
   localparam logic [6:0] LAST_WORD   = 7'd85;
   localparam logic [7:0] REL_LOAD    = 8'(RELEASE_DELAY - 1);
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_MAGIC   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_LOAD    = 3'd2,
      S_RELEASE = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  err_next;
   logic [6:0]  cnt;
   logic [31:0] idle_cnt;
   logic [7:0]  rel_cnt;
   logic        in_stream;
   logic        accept;
   logic        drain;
   logic        last_drain;
   logic        timeout_hit;
   logic [1:0]  slot_space;
   logic [4:0]  slot_idx;

   assign in_stream   = (state == S_HEADER) || (state == S_LOAD);
   assign accept      = in_valid && in_ready;
   assign drain       = wr_valid && wr_ready;
   assign last_drain  = drain && (words_loaded == LAST_WORD);
   // Only cycles with no word offered count as idle; stalls from wr_ready=0 are not idle.
   assign timeout_hit = in_stream && !in_valid && (TIMEOUT_CYCLES != 32'd0) &&
                        (idle_cnt == TIMEOUT_CYCLES - 32'd1);

   assign core_reset_hold = (state != S_DONE);
   assign done            = (state == S_DONE);
   assign error           = (state == S_ERROR);
   assign fsm_state       = state;

   // Payload order: 23 CSR slots, then x1..x31, then f0..f31.
   always_comb begin
      slot_space = 2'd0;
      slot_idx   = cnt[4:0];
      if (cnt < 7'd23) begin
         slot_space = 2'd0;
         slot_idx   = cnt[4:0];
      end else if (cnt < 7'd54) begin
         slot_space = 2'd1;
         slot_idx   = 5'(cnt - 7'd22);
      end else begin
         slot_space = 2'd2;
         slot_idx   = 5'(cnt - 7'd54);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      err_next   = ERR_NONE;
      in_ready   = 1'b0;
      case (state)
         S_IDLE: state_next = enable ? S_HEADER : S_RELEASE;
         S_HEADER: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_bits == MAGIC) begin
                  state_next = S_LOAD;
               end else begin
                  state_next = S_ERROR;
                  err_next   = ERR_MAGIC;
               end
            end else if (timeout_hit) begin
               state_next = S_ERROR;
               err_next   = ERR_TIMEOUT;
            end
         end
         S_LOAD: begin
            in_ready = (cnt != NUM_WORDS) && (!wr_valid || wr_ready);
            if (last_drain) begin
               state_next = S_RELEASE;
            end else if (timeout_hit) begin
               state_next = S_ERROR;
               err_next   = ERR_TIMEOUT;
            end
         end
         S_RELEASE: if (rel_cnt == 8'd0) state_next = S_DONE;
         S_DONE:    state_next = S_DONE;
         S_ERROR:   state_next = S_ERROR;
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt          <= 7'd0;
         idle_cnt     <= 32'd0;
         rel_cnt      <= 8'd0;
         wr_valid     <= 1'b0;
         wr_space     <= 2'd0;
         wr_idx       <= 5'd0;
         wr_data      <= 64'd0;
         words_loaded <= 7'd0;
         error_code   <= ERR_NONE;
      end else begin
         if (!in_stream || accept) idle_cnt <= 32'd0;
         else if (!in_valid)       idle_cnt <= idle_cnt + 32'd1;

         if (state == S_LOAD && accept) cnt <= cnt + 7'd1;

         // A write still pending when the block errors is dropped.
         if (state == S_LOAD && accept) begin
            wr_valid <= 1'b1;
            wr_space <= slot_space;
            wr_idx   <= slot_idx;
            wr_data  <= in_bits;
         end else if (drain || state_next == S_ERROR) begin
            wr_valid <= 1'b0;
         end

         if (drain && words_loaded != NUM_WORDS) words_loaded <= words_loaded + 7'd1;

         // Loaded with DELAY-1 on entry so reset drops DELAY cycles after the entering edge.
         if (state != S_RELEASE && state_next == S_RELEASE) rel_cnt <= REL_LOAD;
         else if (state == S_RELEASE && rel_cnt != 8'd0)    rel_cnt <= rel_cnt - 8'd1;

         if (state != S_ERROR && state_next == S_ERROR) error_code <= err_next;
      end
   end

endmodule

// File: tb/tb_loadarch_restore_sequencer.sv
// Directed bench: happy path, backpressure, bad magic, timeout (drained and pending),
// bypass and reset mid-load, with a write scoreboard fed from an expected queue.
`timescale 1ns/1ps
module tb_loadarch_restore_sequencer;
   localparam logic [63:0] MAGIC = 64'h4C4F_4144_4152_4348;
   localparam int          D     = 16;
   localparam logic [22:0] RST_VEC = {1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0, 3'd0};

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        enable   = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_bits  = 64'd0;
   logic        wr_ready = 1'b1;

   logic        in_ready, wr_valid, core_reset_hold, done, error;
   logic [1:0]  wr_space, error_code;
   logic [4:0]  wr_idx;
   logic [63:0] wr_data;
   logic [6:0]  words_loaded;
   logic [2:0]  fsm_state;

   logic        in_ready_b, wr_valid_b, core_reset_hold_b, done_b, error_b;
   logic [1:0]  wr_space_b, error_code_b;
   logic [4:0]  wr_idx_b;
   logic [63:0] wr_data_b;
   logic [6:0]  words_loaded_b;
   logic [2:0]  fsm_state_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rst_cyc = 0;
   int last_hs = 0;
   int wr_count = 0;
   int bp_mode = 0;
   int bp_ph = 0;
   logic seen_in_ready = 1'b0;
   logic [70:0] last_wr = '0;
   logic [70:0] exp_q[$];

   loadarch_restore_sequencer #(.RELEASE_DELAY(D), .TIMEOUT_CYCLES(32'd50)) dut (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_space(wr_space),
      .wr_idx(wr_idx), .wr_data(wr_data), .core_reset_hold(core_reset_hold), .done(done),
      .error(error), .error_code(error_code), .words_loaded(words_loaded), .fsm_state(fsm_state)
   );

   // Same stimulus, short timeout: must stay error-free under backpressure.
   loadarch_restore_sequencer #(.RELEASE_DELAY(D), .TIMEOUT_CYCLES(32'd8)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_bits(in_bits), .wr_valid(wr_valid_b), .wr_ready(wr_ready), .wr_space(wr_space_b),
      .wr_idx(wr_idx_b), .wr_data(wr_data_b), .core_reset_hold(core_reset_hold_b), .done(done_b),
      .error(error_b), .error_code(error_code_b), .words_loaded(words_loaded_b),
      .fsm_state(fsm_state_b)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #2;
      bp_ph = (bp_ph == 2) ? 0 : bp_ph + 1;
      case (bp_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = (bp_ph == 0);
         default: wr_ready = 1'b0;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ctl"}, 72'({in_ready, wr_valid, wr_space, wr_idx, core_reset_hold, done, error,
                              error_code, words_loaded, fsm_state}), 72'(RST_VEC));
      chk({tag, "_data"}, 72'(wr_data), 72'd0);
   endtask

   function automatic logic [70:0] exp_word(input int i);
      logic [1:0] sp;
      logic [4:0] ix;
      if (i < 23)      begin sp = 2'd0; ix = 5'(i);      end
      else if (i < 54) begin sp = 2'd1; ix = 5'(i - 22); end
      else             begin sp = 2'd2; ix = 5'(i - 54); end
      return {sp, ix, 64'h1000 + 64'(i)};
   endfunction

   // Scoreboard: compare every write handshake with the expected queue and check stall stability.
   task automatic monitor();
      logic        stall = 1'b0;
      logic [70:0] held  = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall = 1'b0;
         end else begin
            if (in_ready) seen_in_ready = 1'b1;
            if (stall && !error)
               chk("wr_hold", {wr_valid, wr_space, wr_idx, wr_data}, {1'b1, held});
            if (wr_valid && wr_ready) begin
               wr_count++;
               last_hs = cyc + 1;
               last_wr = {wr_space, wr_idx, wr_data};
               if (exp_q.size() == 0) chk("wr_extra", 72'(exp_q.size()), 72'd1);
               else                   chk("wr_word", 72'(last_wr), 72'(exp_q.pop_front()));
            end
            stall = wr_valid && !wr_ready;
            held  = {wr_space, wr_idx, wr_data};
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset(input logic en);
      reset = 1'b1; enable = en; in_valid = 1'b0; in_bits = 64'd0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;
      rst_cyc = cyc;
   endtask

   task automatic send(input logic [63:0] w);
      int n;
      in_valid = 1'b1; in_bits = w; n = 0;
      @(negedge clock);
      while (!in_ready && n < 50) begin @(negedge clock); n++; end
      if (!in_ready) chk("in_ready_wait", 72'(in_ready), 72'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic run_stream(input string tag);
      int n;
      for (int i = 0; i < 86; i++) exp_q.push_back(exp_word(i));
      send(MAGIC);
      for (int i = 0; i < 86; i++) send(64'h1000 + 64'(i));
      in_valid = 1'b0;
      n = 0;
      @(negedge clock);
      while (core_reset_hold && n < 400) begin @(negedge clock); n++; end
      chk({tag, "_hold"}, 72'(core_reset_hold), 72'd0);
      chk({tag, "_release_gap"}, 72'(cyc - last_hs), 72'(D));
      chk({tag, "_done"}, 72'({done, error, words_loaded}), 72'({1'b1, 1'b0, 7'd86}));
      chk({tag, "_qempty"}, 72'(exp_q.size()), 72'd0);
      chk({tag, "_last"}, 72'(last_wr), 72'({2'd2, 5'd31, 64'h1055}));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int t0;
      int wc0;
      logic pv;
      fork monitor(); join_none

      // happy path
      do_reset(1'b1);
      run_stream("happy");
      chk("happy_total", 72'(cyc - rst_cyc), 72'(89 + D));
      in_valid = 1'b1; in_bits = MAGIC;
      repeat (5) begin @(negedge clock); chk("done_in_ready", 72'(in_ready), 72'd0); end
      chk("done_sticky", 72'({done, core_reset_hold, words_loaded}), 72'({1'b1, 1'b0, 7'd86}));

      // backpressure, wr_ready high one cycle in three
      bp_mode = 1;
      do_reset(1'b1);
      run_stream("bp");
      chk("bp_short_timeout", 72'({done_b, error_b, error_code_b, words_loaded_b}),
          72'({1'b1, 1'b0, 2'd0, 7'd86}));
      bp_mode = 0;

      // bad magic
      do_reset(1'b1);
      wc0 = wr_count;
      send(64'hDEAD);
      @(negedge clock);
      chk("magic_err", 72'({error, error_code, core_reset_hold, in_ready, wr_valid}),
          72'({1'b1, 2'd1, 1'b1, 1'b0, 1'b0}));
      in_bits = MAGIC;
      repeat (20) @(negedge clock);
      chk("magic_stuck", 72'({error, error_code, core_reset_hold, done, in_ready}),
          72'({1'b1, 2'd1, 1'b1, 1'b0, 1'b0}));
      chk("magic_writes", 72'(wr_count - wc0), 72'd0);

      // timeout with last write drained
      do_reset(1'b1);
      for (int i = 0; i <= 40; i++) exp_q.push_back(exp_word(i));
      send(MAGIC);
      for (int i = 0; i <= 40; i++) send(64'h1000 + 64'(i));
      in_valid = 1'b0;
      t0 = cyc; n = 0;
      @(negedge clock);
      while (!error && n < 200) begin @(negedge clock); n++; end
      chk("to_gap", 72'(cyc - t0), 72'd50);
      chk("to_state", 72'({error, error_code, words_loaded, wr_valid, core_reset_hold}),
          72'({1'b1, 2'd2, 7'd41, 1'b0, 1'b1}));
      repeat (30) @(negedge clock);
      chk("to_no_release", 72'({core_reset_hold, done, error}), 72'({1'b1, 1'b0, 1'b1}));
      chk("to_qempty", 72'(exp_q.size()), 72'd0);

      // timeout with last write still pending
      do_reset(1'b1);
      for (int i = 0; i <= 40; i++) exp_q.push_back(exp_word(i));
      send(MAGIC);
      for (int i = 0; i <= 40; i++) send(64'h1000 + 64'(i));
      in_valid = 1'b0;
      bp_mode = 2;
      t0 = cyc; n = 0; pv = 1'b0;
      @(negedge clock);
      while (!error && n < 200) begin pv = wr_valid; @(negedge clock); n++; end
      chk("pend_gap", 72'(cyc - t0), 72'd50);
      chk("pend_before", 72'(pv), 72'd1);
      chk("pend_state", 72'({error_code, words_loaded, wr_valid}), 72'({2'd2, 7'd40, 1'b0}));
      chk("pend_q", 72'(exp_q.size()), 72'd1);
      exp_q.delete();
      bp_mode = 0;

      // bypass
      do_reset(1'b0);
      in_valid = 1'b1; in_bits = MAGIC;
      seen_in_ready = 1'b0; wc0 = wr_count; n = 0;
      @(negedge clock);
      while (core_reset_hold && n < 100) begin @(negedge clock); n++; end
      chk("byp_gap", 72'(cyc - rst_cyc), 72'(1 + D));
      chk("byp_done", 72'({done, core_reset_hold, words_loaded}), 72'({1'b1, 1'b0, 7'd0}));
      repeat (5) @(negedge clock);
      chk("byp_no_ready", 72'(seen_in_ready), 72'd0);
      chk("byp_writes", 72'(wr_count - wc0), 72'd0);

      // reset mid-load, then full replay
      do_reset(1'b1);
      for (int i = 0; i < 30; i++) exp_q.push_back(exp_word(i));
      send(MAGIC);
      for (int i = 0; i < 30; i++) send(64'h1000 + 64'(i));
      reset = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      chk("mid_pending", 72'(exp_q.size()), 72'd1);
      exp_q.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      rst_cyc = cyc;
      run_stream("replay");
      chk("replay_total", 72'(cyc - rst_cyc), 72'(89 + D));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
